pop_shot_sequencer: RTL

//  Sequences one POP measurement shot (pump -> dark -> probe) by driving an external WIDTH-bit
//  up/down counter (clk/direction/reset/count) as the shot timebase. Phase edges are compared

---
 rtl/pop_shot_sequencer_if.sv | 31 +++
 rtl/pop_shot_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pop_shot_sequencer_if.sv
// rtl/pop_shot_sequencer_if.sv - host config, counter link and gate outputs of pop_shot_sequencer
interface pop_shot_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int SHOT_W = 8
);
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  t_pump;
  logic [WIDTH-1:0]  t_dark;
  logic [WIDTH-1:0]  t_probe;
  logic [SHOT_W-1:0] n_shots;
  logic [WIDTH-1:0]  ctr_count;
  logic              ctr_reset;
  logic              ctr_dir;
  logic              pump_o;
  logic              probe_o;
  logic              acq_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start, abort, t_pump, t_dark, t_probe, n_shots, ctr_count,
    input  ctr_reset, ctr_dir, pump_o, probe_o, acq_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start, abort, t_pump, t_dark, t_probe, n_shots, ctr_count,
    output ctr_reset, ctr_dir, pump_o, probe_o, acq_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/pop_shot_sequencer.sv
// rtl/pop_shot_sequencer.sv - pump/dark/probe shot sequencer timed by an external up counter
// Define POP_SEQ_REPEAT_EN to repeat n_shots shots back-to-back per start.
module pop_shot_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SHOT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  pop_shot_sequencer_if.slave bus
);
  localparam int LW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len_in;
  logic [LW-1:0] cnt;
  logic [LW-1:0] end_pump, end_dark, end_len;
  logic          start_ok, start_bad, last_cnt, more_shots;
  logic          ctr_reset_d, busy_d, pump_d, probe_d, done_d, err_d;

  assign len_in    = LW'(bus.t_pump) + LW'(bus.t_dark) + LW'(bus.t_probe);
  assign cnt       = LW'(bus.ctr_count);
  assign start_bad = (len_in == '0) || (len_in > (LW'(1) << WIDTH));
  assign start_ok  = (state == IDLE) && bus.start && !bus.abort && !start_bad;
  assign last_cnt  = (cnt == end_len - LW'(1));

  // Phase edges held as cumulative end points so each gate is a plain compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      end_pump <= '0;
      end_dark <= '0;
      end_len  <= '0;
    end else if (start_ok) begin
      end_pump <= LW'(bus.t_pump);
      end_dark <= LW'(bus.t_pump) + LW'(bus.t_dark);
      end_len  <= len_in;
    end
  end

`ifdef POP_SEQ_REPEAT_EN
  logic [SHOT_W-1:0] shots_left;

  assign more_shots = shots_left > SHOT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shots_left <= '0;
    end else if (start_ok) begin
      shots_left <= (bus.n_shots == '0) ? SHOT_W'(1) : bus.n_shots;
    end else if ((state == TAIL) && more_shots && !bus.abort) begin
      shots_left <= shots_left - SHOT_W'(1);
    end
  end
`else
  logic unused_n_shots;

  assign unused_n_shots = ^bus.n_shots;
  assign more_shots     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = RUN;
        RUN:     if (last_cnt) state_nxt = TAIL;
        TAIL:    state_nxt = more_shots ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; gates lag the counter by one cycle.
  always_comb begin
    ctr_reset_d = (state_nxt != RUN);
    busy_d      = (state_nxt != IDLE);
    pump_d      = 1'b0;
    probe_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    if (!bus.abort) begin
      if (state == RUN) begin
        pump_d  = (cnt < end_pump);
        probe_d = (cnt >= end_dark) && (cnt < end_len);
      end
      done_d = (state == TAIL) && (state_nxt == IDLE);
      err_d  = (state == IDLE) && bus.start && start_bad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ctr_reset <= 1'b1;
      bus.busy_o    <= 1'b0;
      bus.pump_o    <= 1'b0;
      bus.probe_o   <= 1'b0;
      bus.acq_o     <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.err_o     <= 1'b0;
    end else begin
      bus.ctr_reset <= ctr_reset_d;
      bus.busy_o    <= busy_d;
      bus.pump_o    <= pump_d;
      bus.probe_o   <= probe_d;
      bus.acq_o     <= probe_d;
      bus.done_o    <= done_d;
      bus.err_o     <= err_d;
    end
  end

  assign bus.ctr_dir = 1'b1;
endmodule
